// File: rtl/lw_bridge_responder.sv
// lw_bridge_responder: Avalon-MM responder on the HPS lightweight bridge.
// Provides ID and scratch registers, an edge-triggered interrupt controller,
// a host-to-fabric mailbox FIFO and a free-running tick counter.
// Single-beat transfers only; reads complete with a fixed 2-cycle latency.
module lw_bridge_responder #(
  parameter logic [31:0] ID_VALUE   = 32'h4D4E_0001,
  parameter int          FIFO_DEPTH = 16,
  parameter int          NUM_EVT    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [17:0]        avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic [3:0]         avs_byteenable,
  input  logic               avs_burstcount,
  output logic               avs_waitrequest,
  output logic [31:0]        avs_readdata,
  output logic               avs_readdatavalid,
  input  logic [NUM_EVT-1:0] evt_i,
  output logic               irq_o,
  output logic [31:0]        mbx_data_o,
  output logic               mbx_valid_o,
  input  logic               mbx_ready_i
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);

  localparam logic [2:0] REG_ID      = 3'd0;
  localparam logic [2:0] REG_SCRATCH = 3'd1;
  localparam logic [2:0] REG_PEND    = 3'd2;
  localparam logic [2:0] REG_EN      = 3'd3;
  localparam logic [2:0] REG_MBXDATA = 3'd4;
  localparam logic [2:0] REG_MBXSTAT = 3'd5;
  localparam logic [2:0] REG_TICK    = 3'd6;

  typedef enum logic [1:0] {IDLE = 2'd0, LAT = 2'd1, RESP = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          scratch_q, scratch_d;
  logic [NUM_EVT-1:0]   pend_q, pend_d;
  logic [NUM_EVT-1:0]   en_q, en_d;
  logic [NUM_EVT-1:0]   evt_prev_q;
  logic                 irq_q, irq_d;
  logic [31:0]          tick_q;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          mem_q [FIFO_DEPTH];

  logic                 mapped;
  logic [2:0]           sel;
  logic                 rd_acc, wr_acc;
  logic [31:0]          rd_snap;
  logic [8:0]           level;
  logic                 full, empty, push, pop, push_ok;
  logic [NUM_EVT-1:0]   pend_clr;
  logic                 unused_bits;

  // Burst count and the byte-offset bits carry no information for this block.
  assign unused_bits = ^{avs_burstcount, avs_address[1:0]};

  // Stall only while in reset or while a read waits out its latency cycle.
  assign avs_waitrequest   = reset | (state_q == LAT);
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq_o             = irq_q;
  assign mbx_valid_o       = ~empty;
  assign mbx_data_o        = mem_q[rd_ptr_q];

  // Decode the command; a read wins over a simultaneous write.
  always_comb begin
    mapped = (avs_address[17:5] == '0);
    sel    = avs_address[4:2];
    rd_acc = avs_read & ~avs_waitrequest;
    wr_acc = avs_write & ~avs_read & ~avs_waitrequest & mapped;
  end

  // Read snapshot taken from current register state, before any same-edge update.
  always_comb begin
    level   = 9'(count_q);
    rd_snap = '0;
    if (mapped) begin
      case (sel)
        REG_ID:      rd_snap = ID_VALUE;
        REG_SCRATCH: rd_snap = scratch_q;
        REG_PEND:    rd_snap = 32'(pend_q);
        REG_EN:      rd_snap = 32'(en_q);
        REG_MBXSTAT: rd_snap = {7'b0, ovf_q, 6'b0, empty, full, 7'b0, level};
        REG_TICK:    rd_snap = tick_q;
        default:     rd_snap = '0;
      endcase
    end
  end

  // Responder FSM: capture on accept, one latency cycle, one response cycle.
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_acc) begin
          state_d = LAT;
          rdata_d = rd_snap;
        end
      end
      LAT: begin
        state_d  = RESP;
        rvalid_d = 1'b1;
      end
      RESP: begin
        if (rd_acc) begin
          state_d = LAT;
          rdata_d = rd_snap;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register updates: scratch byte lanes, W1C pending with set priority, enables.
  always_comb begin
    scratch_d = scratch_q;
    en_d      = en_q;
    pend_clr  = '0;
    if (wr_acc && sel == REG_SCRATCH) begin
      for (int i = 0; i < 4; i++) begin
        if (avs_byteenable[i]) scratch_d[8*i +: 8] = avs_writedata[8*i +: 8];
      end
    end
    if (wr_acc && sel == REG_EN) en_d = avs_writedata[NUM_EVT-1:0];
    if (wr_acc && sel == REG_PEND) pend_clr = avs_writedata[NUM_EVT-1:0];
    pend_d = (pend_q & ~pend_clr) | (evt_i & ~evt_prev_q);
    irq_d  = |(pend_q & en_q);
  end

  // Mailbox bookkeeping: a pop frees the slot a same-cycle push into a full FIFO needs.
  always_comb begin
    full     = (count_q == FULL_LEVEL);
    empty    = (count_q == '0);
    push     = wr_acc && (sel == REG_MBXDATA);
    pop      = ~empty & mbx_ready_i;
    push_ok  = push & (~full | pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    ovf_d    = ovf_q;
    if (wr_acc && sel == REG_MBXSTAT && avs_writedata[24]) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  // Responder state and registered read response; reset aborts an in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Control/status registers, event history, interrupt, tick and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q  <= '0;
      pend_q     <= '0;
      en_q       <= '0;
      evt_prev_q <= '0;
      irq_q      <= 1'b0;
      tick_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      evt_prev_q <= evt_i;
      irq_q      <= irq_d;
      tick_q     <= tick_q + 32'd1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Mailbox storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= avs_writedata;
  end

endmodule

// File: tb/tb_lw_bridge_responder.sv
// tb_lw_bridge_responder: self-checking bench for lw_bridge_responder.
// A behavioural model (queue for the mailbox, plain variables for the
// registers, an elapsed-cycle count for TICK) supplies every expected value.
module tb_lw_bridge_responder;

  localparam logic [31:0] ID = 32'h4D4E_0001;
  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic [17:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_burstcount;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [3:0]  evt_i;
  logic        irq_o;
  logic [31:0] mbx_data_o;
  logic        mbx_valid_o;
  logic        mbx_ready_i;

  int checks = 0;
  int failures = 0;

  logic [31:0] scratch_m;
  logic [3:0]  pend_m;
  logic [3:0]  en_m;
  logic        ovf_m;
  logic [31:0] fifo_m[$];
  int unsigned cyc;

  lw_bridge_responder #(.ID_VALUE(ID), .FIFO_DEPTH(DEPTH), .NUM_EVT(4)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_burstcount(avs_burstcount), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .evt_i(evt_i), .irq_o(irq_o),
    .mbx_data_o(mbx_data_o), .mbx_valid_o(mbx_valid_o), .mbx_ready_i(mbx_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Elapsed clock edges since reset was last released: the expected TICK value.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic logic [31:0] stat_model();
    logic [31:0] s;
    s = '0;
    s[8:0] = 9'(fifo_m.size());
    s[16]  = (fifo_m.size() == DEPTH);
    s[17]  = (fifo_m.size() == 0);
    s[24]  = ovf_m;
    return s;
  endfunction

  task automatic bus_read(input logic [17:0] a, output logic [31:0] d, output int lat);
    int n;
    @(negedge clk);
    avs_address = a;
    avs_read = 1'b1;
    n = 0;
    while (avs_waitrequest && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    avs_read = 1'b0;
    lat = 1;
    while (!avs_readdatavalid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (avs_readdatavalid) d = avs_readdata;
    else begin
      d = '0;
      lat = -1;
    end
  endtask

  task automatic bus_write(input logic [17:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    @(negedge clk);
    avs_address = a;
    avs_writedata = d;
    avs_byteenable = be;
    avs_write = 1'b1;
    n = 0;
    while (avs_waitrequest && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic drain_fifo(input string tag);
    int budget;
    logic [31:0] tmp;
    budget = 0;
    @(negedge clk);
    mbx_ready_i = 1'b1;
    while (fifo_m.size() > 0 && budget < 100) begin
      checks++;
      if (mbx_valid_o !== 1'b1 || mbx_data_o !== fifo_m[0]) begin
        failures++;
        $display("[TB] FAIL %s_pop valid=%b data=%h expected valid=1 data=%h", tag, mbx_valid_o, mbx_data_o, fifo_m[0]);
        break;
      end
      tmp = fifo_m.pop_front();
      budget++;
      @(negedge clk);
    end
    mbx_ready_i = 1'b0;
    checks++;
    if (mbx_valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_empty valid=%b expected 0", tag, mbx_valid_o);
    end
    fifo_m.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    avs_byteenable = 4'hF; avs_burstcount = 1'b1; evt_i = '0; mbx_ready_i = 1'b0;
    scratch_m = '0; pend_m = '0; en_m = '0; ovf_m = 1'b0; fifo_m.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (avs_waitrequest !== 1'b1 || avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0 ||
        irq_o !== 1'b0 || mbx_valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs wr=%b rv=%b rd=%h irq=%b mv=%b expected 1 0 0 0 0",
               avs_waitrequest, avs_readdatavalid, avs_readdata, irq_o, mbx_valid_o);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (avs_waitrequest !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_wait got=%b expected 0", avs_waitrequest);
    end
    @(negedge clk);
    avs_address = 18'h0;
    avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    checks++;
    if (avs_waitrequest !== 1'b1 || avs_readdatavalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL id_mid_cycle wr=%b rv=%b expected wr=1 rv=0", avs_waitrequest, avs_readdatavalid);
    end
    @(negedge clk);
    checks++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== ID || avs_waitrequest !== 1'b0) begin
      failures++;
      $display("[TB] FAIL id_response rv=%b data=%h wr=%b expected rv=1 data=%h wr=0",
               avs_readdatavalid, avs_readdata, avs_waitrequest, ID);
    end
    @(negedge clk);
    checks++;
    if (avs_readdatavalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL id_single_strobe rv=%b expected 0", avs_readdatavalid);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d, wd;
    logic [3:0] be;
    int lat;
    bus_write(18'h04, 32'hAABBCCDD, 4'b0101);
    scratch_m = 32'h00BB00DD;
    bus_read(18'h04, d, lat);
    checks++;
    if (d !== scratch_m || lat != 2) begin
      failures++;
      $display("[TB] FAIL scratch_be got=%h lat=%0d expected %h lat=2", d, lat, scratch_m);
    end
    bus_read(18'h20, d, lat);
    checks++;
    if (d !== 32'h0 || lat != 2) begin
      failures++;
      $display("[TB] FAIL unmapped_read got=%h lat=%0d expected 0 lat=2", d, lat);
    end
    bus_read(18'h1C, d, lat);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reserved_read got=%h expected 0", d);
    end
    bus_write(18'h24, 32'h12345678, 4'hF);
    bus_write(18'h00, 32'hFFFFFFFF, 4'hF);
    bus_read(18'h04, d, lat);
    checks++;
    if (d !== scratch_m) begin
      failures++;
      $display("[TB] FAIL unmapped_write_ignored got=%h expected %h", d, scratch_m);
    end
    bus_read(18'h00, d, lat);
    checks++;
    if (d !== ID) begin
      failures++;
      $display("[TB] FAIL id_read_only got=%h expected %h", d, ID);
    end
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      bus_write(18'h04 | 18'($urandom_range(0, 3)), wd, be);
      for (int b = 0; b < 4; b++) if (be[b]) scratch_m[8*b +: 8] = wd[8*b +: 8];
      bus_read(18'h04, d, lat);
      checks++;
      if (d !== scratch_m) begin
        failures++;
        $display("[TB] FAIL scratch_random[%0d] got=%h expected %h", i, d, scratch_m);
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] d, wv;
    logic [3:0] vec, clr;
    int lat;
    bus_write(18'h0C, 32'h1, 4'hF);
    en_m = 4'h1;
    @(negedge clk);
    evt_i = 4'h1;
    @(negedge clk);
    evt_i = 4'h0;
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_edge_t1 got=%b expected 0", irq_o);
    end
    @(negedge clk);
    checks++;
    if (irq_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL irq_edge_t2 got=%b expected 1", irq_o);
    end
    pend_m = 4'h1;
    bus_read(18'h08, d, lat);
    checks++;
    if (d !== 32'(pend_m)) begin
      failures++;
      $display("[TB] FAIL pend_read got=%h expected %h", d, 32'(pend_m));
    end
    @(negedge clk);
    avs_address = 18'h08; avs_writedata = 32'h1; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    checks++;
    if (irq_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL irq_clear_t1 got=%b expected 1", irq_o);
    end
    @(negedge clk);
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_clear_t2 got=%b expected 0", irq_o);
    end
    pend_m = 4'h0;
    @(negedge clk);
    avs_address = 18'h08; avs_writedata = 32'h1; avs_write = 1'b1; evt_i = 4'h1;
    @(negedge clk);
    avs_write = 1'b0; evt_i = 4'h0;
    pend_m = 4'h1;
    bus_read(18'h08, d, lat);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL set_beats_clear got=%h expected 1", d);
    end
    for (int i = 0; i < 6; i++) begin
      wv = $urandom;
      bus_write(18'h0C, wv, 4'h0);
      en_m = wv[3:0];
      vec = 4'($urandom_range(0, 15));
      @(negedge clk);
      evt_i = vec;
      @(negedge clk);
      evt_i = 4'h0;
      pend_m = pend_m | vec;
      @(negedge clk);
      checks++;
      if (irq_o !== |(pend_m & en_m)) begin
        failures++;
        $display("[TB] FAIL irq_random[%0d] got=%b expected %b", i, irq_o, |(pend_m & en_m));
      end
      bus_read(18'h08, d, lat);
      checks++;
      if (d !== 32'(pend_m)) begin
        failures++;
        $display("[TB] FAIL pend_random[%0d] got=%h expected %h", i, d, 32'(pend_m));
      end
      bus_read(18'h0C, d, lat);
      checks++;
      if (d !== 32'(en_m)) begin
        failures++;
        $display("[TB] FAIL en_random[%0d] got=%h expected %h", i, d, 32'(en_m));
      end
      clr = 4'($urandom_range(0, 15));
      bus_write(18'h08, 32'(clr), 4'hF);
      pend_m = pend_m & ~clr;
    end
    bus_write(18'h0C, 32'h0, 4'hF);
    bus_write(18'h08, 32'hF, 4'hF);
    en_m = '0;
    pend_m = '0;
  endtask

  task automatic test_mailbox();
    logic [31:0] d;
    int lat;
    mbx_ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus_write(18'h10, 32'(i), 4'hF);
      if (fifo_m.size() < DEPTH) fifo_m.push_back(32'(i));
      else ovf_m = 1'b1;
    end
    bus_read(18'h14, d, lat);
    checks++;
    if (d !== stat_model() || d !== 32'h0101_0010) begin
      failures++;
      $display("[TB] FAIL stat_full_ovf got=%h expected %h", d, stat_model());
    end
    drain_fifo("fill17");
    bus_read(18'h14, d, lat);
    checks++;
    if (d !== 32'h0102_0000) begin
      failures++;
      $display("[TB] FAIL stat_drained got=%h expected 01020000", d);
    end
    bus_write(18'h14, 32'h0100_0000, 4'hF);
    ovf_m = 1'b0;
    bus_write(18'h10, 32'h55, 4'hF);
    fifo_m.push_back(32'h55);
    bus_read(18'h10, d, lat);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL mbx_data_read got=%h expected 0", d);
    end
    bus_read(18'h14, d, lat);
    checks++;
    if (d !== stat_model()) begin
      failures++;
      $display("[TB] FAIL stat_after_read got=%h expected %h", d, stat_model());
    end
    drain_fifo("single");
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d, tmp;
    int lat;
    for (int i = 0; i < DEPTH; i++) begin
      bus_write(18'h10, 32'h100 + 32'(i), 4'hF);
      fifo_m.push_back(32'h100 + 32'(i));
    end
    @(negedge clk);
    avs_address = 18'h10; avs_writedata = 32'hCAFE; avs_write = 1'b1; mbx_ready_i = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; mbx_ready_i = 1'b0;
    tmp = fifo_m.pop_front();
    fifo_m.push_back(32'hCAFE);
    bus_read(18'h14, d, lat);
    checks++;
    if (d !== stat_model() || d !== 32'h0001_0010) begin
      failures++;
      $display("[TB] FAIL full_push_pop_stat got=%h expected %h", d, stat_model());
    end
    drain_fifo("fullpp");
  endtask

  task automatic test_fifo_random();
    logic [31:0] d, wd, tmp;
    logic push, rdy, pop, full;
    int lat;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      checks++;
      if (mbx_valid_o !== (fifo_m.size() != 0)) begin
        failures++;
        $display("[TB] FAIL rand_valid[%0d] got=%b expected %b", i, mbx_valid_o, fifo_m.size() != 0);
      end
      if (fifo_m.size() != 0) begin
        checks++;
        if (mbx_data_o !== fifo_m[0]) begin
          failures++;
          $display("[TB] FAIL rand_data[%0d] got=%h expected %h", i, mbx_data_o, fifo_m[0]);
        end
      end
      push = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 2) == 0);
      wd   = $urandom;
      avs_address = 18'h10; avs_writedata = wd; avs_write = push; mbx_ready_i = rdy;
      pop  = rdy && (fifo_m.size() != 0);
      full = (fifo_m.size() == DEPTH);
      if (pop) tmp = fifo_m.pop_front();
      if (push) begin
        if (full && !pop) ovf_m = 1'b1;
        else fifo_m.push_back(wd);
      end
    end
    @(negedge clk);
    avs_write = 1'b0; mbx_ready_i = 1'b0;
    bus_read(18'h14, d, lat);
    checks++;
    if (d !== stat_model()) begin
      failures++;
      $display("[TB] FAIL rand_stat got=%h expected %h", d, stat_model());
    end
    drain_fifo("random");
    bus_write(18'h14, 32'h0100_0000, 4'hF);
    ovf_m = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2;
    int unsigned t0, t1;
    @(negedge clk);
    avs_address = 18'h18; avs_read = 1'b1;
    t0 = cyc;
    @(negedge clk);
    @(negedge clk);
    t1 = cyc;
    d1 = avs_readdata;
    checks++;
    if (avs_readdatavalid !== 1'b1 || d1 !== t0) begin
      failures++;
      $display("[TB] FAIL tick_first rv=%b got=%h expected %h", avs_readdatavalid, d1, t0);
    end
    @(negedge clk);
    avs_read = 1'b0;
    checks++;
    if (avs_readdatavalid !== 1'b0 || avs_waitrequest !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_latency_cycle rv=%b wr=%b expected rv=0 wr=1", avs_readdatavalid, avs_waitrequest);
    end
    @(negedge clk);
    d2 = avs_readdata;
    checks++;
    if (avs_readdatavalid !== 1'b1 || d2 !== t1 || d2 - d1 !== 32'd2) begin
      failures++;
      $display("[TB] FAIL tick_second rv=%b got=%h expected %h diff=%0d", avs_readdatavalid, d2, t1, d2 - d1);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    int lat;
    int seen;
    @(negedge clk);
    avs_address = 18'h0; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (avs_readdatavalid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("[TB] FAIL reset_abort valid_cycles=%0d expected 0", seen);
    end
    reset = 1'b0;
    scratch_m = '0;
    bus_read(18'h04, d, lat);
    checks++;
    if (d !== scratch_m || lat != 2) begin
      failures++;
      $display("[TB] FAIL post_reset_scratch got=%h lat=%0d expected %h lat=2", d, lat, scratch_m);
    end
  endtask

  initial begin
    test_reset();
    test_scratch();
    test_irq();
    test_mailbox();
    test_full_push_pop();
    test_fifo_random();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lw_bridge_responder.md
# lw_bridge_responder

Avalon-MM responder attached to the HPS lightweight-bridge master (`lw_bridge_m0`) of the DE10-Nano SoC host system. It gives the ARM host the following resources:
- an ID register and a scratch register
- a 4-source event/interrupt controller whose output drives `hostif_irq_i_irq`
- a host-to-fabric mailbox FIFO, drained by fabric logic through a valid/ready handshake
- a free-running tick counter

It serves only single-beat transfers, with fixed 2-cycle read latency.

## Interface
Parameters:
- `ID_VALUE`, 32'h4D4E_0001: constant returned by the ID register.
- `FIFO_DEPTH`, 16: mailbox depth; a power of two, 2..256.
- `NUM_EVT`, 4: number of event/IRQ sources, 1..16.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, the `clk100_clk` domain.
- `reset` in 1: synchronous, active-high reset.
- `avs_address` in 18: byte address. Bits [1:0] are ignored; bits [4:2] select the register; bits [17:5] nonzero means unmapped.
- `avs_read` in 1: read command.
- `avs_write` in 1: write command.
- `avs_writedata` in 32: write data.
- `avs_byteenable` in 4: byte lanes. Honoured for SCRATCH only; other registers use the full word.
- `avs_burstcount` in 1: always 1; the value is ignored.
- `avs_waitrequest` out 1: command stall.
- `avs_readdata` out 32: read data, qualified by `avs_readdatavalid`.
- `avs_readdatavalid` out 1: one-cycle read-response strobe.
- `evt_i` in NUM_EVT: synchronous event inputs.
- `irq_o` out 1: level interrupt to the host.
- `mbx_data_o` out 32: mailbox head word.
- `mbx_valid_o` out 1: mailbox not empty.
- `mbx_ready_i` in 1: consumer pop. A pop occurs when `mbx_valid_o` and `mbx_ready_i` are both high.

## Operation
Register map (byte offsets):
- 0x00 ID: RO, returns `ID_VALUE`.
- 0x04 SCRATCH: RW, per-byte enable. Reset value 0.
- 0x08 IRQ_PEND: bits [NUM_EVT-1:0]. Writing 1 clears a bit (W1C). Reset value 0.
- 0x0C IRQ_EN: RW, bits [NUM_EVT-1:0]. Reset value 0.
- 0x10 MBX_DATA: a write pushes `avs_writedata`. Reads return 0 and do not pop.
- 0x14 MBX_STAT: RO except bit [24].
  - [8:0] level.
  - [16] full.
  - [17] empty.
  - [24] overflow, sticky; cleared by writing 1 to bit 24 (W1C).
- 0x18 TICK: RO, 32-bit counter that increments every cycle and wraps from 0xFFFFFFFF to 0.
- 0x1C and all unmapped addresses: reads return 0; writes are ignored.

Responder FSM:
- States are IDLE, LAT, and RESP.
- IDLE → LAT when a read is accepted.
- LAT → RESP unconditionally.
- RESP → IDLE, or RESP → LAT if another read is accepted in RESP.
- Writes are accepted in IDLE and RESP and do not change state.

Command rules:
- If `avs_read` and `avs_write` are high in the same cycle, the read is served and the write is dropped.

Events and interrupt:
- Edge detection: `evt_i[k]` high in the current cycle and low in the previous cycle sets `IRQ_PEND[k]`.
- If an edge set and a W1C clear hit the same bit in the same cycle, the set wins.
- `irq_o` is registered: `irq_o` = |(IRQ_PEND & IRQ_EN).

Mailbox:
- Push onto a full FIFO: the word is dropped and overflow is set, unless a pop occurs in the same cycle. With a same-cycle pop the push is accepted and the level is unchanged.
- Simultaneous push and pop on a non-empty FIFO: level unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.
- `mbx_data_o` is valid whenever `mbx_valid_o` is high.

Reset values:
- `avs_waitrequest`: 1 while `reset` is high.
- `avs_readdatavalid`, `avs_readdata`, `irq_o`, `mbx_valid_o`: 0.
- TICK: 0.
- FIFO: empty, overflow 0. The edge-detect history register is cleared.
- Reset asserted mid-read aborts the read; no `avs_readdatavalid` is produced.

## Timing
- A command is accepted in a cycle where (`avs_read` | `avs_write`) is high and `avs_waitrequest` is low.
- Read accepted in cycle T:
  - Read data is a snapshot of register state in cycle T, before any same-edge updates. TICK returns its cycle-T value.
  - `avs_waitrequest` = 1 in T+1.
  - `avs_readdatavalid` = 1 for exactly one cycle, in T+2, with `avs_readdata`; `avs_waitrequest` = 0 in T+2.
  - Maximum read throughput is one read per 2 cycles.
- Write accepted in cycle T: the register or FIFO is updated at the edge ending T and is visible from T+1. Back-to-back writes proceed every cycle.
- Event edge at cycle T: IRQ_PEND is set in T+1; `irq_o` rises in T+2 if enabled.
- Clearing pending or enable at cycle T: `irq_o` falls in T+2.
- Push at T into an empty FIFO: `mbx_valid_o` = 1 in T+1.
- `avs_waitrequest` = 0 in the first cycle after `reset` deasserts.

## Test plan
- Reset, then read 0x00: `avs_readdatavalid` exactly 2 cycles after acceptance, data 0x4D4E0001; `avs_waitrequest` high only in the middle cycle.
- Write 0x04 = 0xAABBCCDD with byteenable 4'b0101, starting from 0: readback is 0x00BB00DD. Read 0x20 returns 0.
- IRQ_EN = 0x1. Pulse `evt_i[0]` → `irq_o` high 2 cycles after the edge. Write 0x08 = 0x1 → `irq_o` low 2 cycles later. Edge and W1C in the same cycle → pending stays 1.
- With `mbx_ready_i` = 0, push 17 words 0..16 (FIFO_DEPTH 16): MBX_STAT = level 16, full, overflow set. Raise ready: pops 0..15 in order, and empty asserts after 16 pops.
- FIFO full, push coincident with a pop: level stays 16, overflow stays 0, and the new word is delivered last.
- Read TICK twice, accepted 2 cycles apart: difference is exactly 2. Assert `reset` at T+1 of a read: no `avs_readdatavalid` appears.
